// File: rtl/etapa_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   DEF_HALT_INSTR : instruction word that stops fetch
//   NOP_INSTR      : encoding loaded into IF/ID for a bubble
//   DEF_PC_STEP    : sequential PC increment (byte addressing)
//   fetch_state_e  : fetch FSM states
package etapa_fetch_pkg;

   localparam logic [31:0] DEF_HALT_INSTR = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
   localparam int unsigned DEF_PC_STEP    = 4;

   typedef enum logic [0:0] {
      StRun    = 1'b0,
      StHalted = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/etapa_fetch_registro_ifid.sv
// IF/ID pipeline register.
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_bubble       : load a bubble (NOP, pc4 = 0, invalid); wins over i_load
//   i_load         : load i_instr / i_pc4 / i_valid
//   o_instr, o_pc4, o_valid : registered IF/ID contents
// With neither control asserted the register holds.
module registro_ifid
   import etapa_fetch_pkg::*;
#(
   parameter int unsigned NBITS = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_bubble,
   input  logic [NBITS-1:0] i_instr,
   input  logic [NBITS-1:0] i_pc4,
   input  logic             i_valid,
   output logic [NBITS-1:0] o_instr,
   output logic [NBITS-1:0] o_pc4,
   output logic             o_valid
);

   logic [NBITS-1:0] instr_q;
   logic [NBITS-1:0] pc4_q;
   logic             valid_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         instr_q <= NBITS'(NOP_INSTR);
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else if (i_bubble) begin
         instr_q <= NBITS'(NOP_INSTR);
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else if (i_load) begin
         instr_q <= i_instr;
         pc4_q   <= i_pc4;
         valid_q <= i_valid;
      end
   end

   assign o_instr = instr_q;
   assign o_pc4   = pc4_q;
   assign o_valid = valid_q;

endmodule

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage of the five-stage MIPS pipeline.
//   i_clk, i_rst_n        : clock and asynchronous active-low reset
//   i_enable              : debug run/step gate, 0 freezes the stage
//   i_stall               : hazard stall, holds PC and IF/ID
//   i_branch_taken/target : taken branch redirect
//   i_jump/target         : jump redirect (wins over branch)
//   i_instruction         : instruction memory data, one cycle after o_PC
//   o_PC                  : fetch address
//   o_ifid_instr/pc4/valid: IF/ID register contents
//   o_halted              : fetch stopped on the halt word
module etapa_fetch
   import etapa_fetch_pkg::*;
#(
   parameter int unsigned     NBITS      = 32,
   parameter logic [NBITS-1:0] PC_RESET   = '0,
   parameter logic [NBITS-1:0] PC_STEP    = NBITS'(DEF_PC_STEP),
   parameter logic [NBITS-1:0] HALT_INSTR = NBITS'(DEF_HALT_INSTR)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic             i_stall,
   input  logic             i_branch_taken,
   input  logic [NBITS-1:0] i_branch_target,
   input  logic             i_jump,
   input  logic [NBITS-1:0] i_jump_target,
   input  logic [NBITS-1:0] i_instruction,
   output logic [NBITS-1:0] o_PC,
   output logic [NBITS-1:0] o_ifid_instr,
   output logic [NBITS-1:0] o_ifid_pc4,
   output logic             o_ifid_valid,
   output logic             o_halted
);

   fetch_state_e     state_q;
   logic [NBITS-1:0] pc_q;
   logic [NBITS-1:0] inflight_pc_q;
   logic             inflight_valid_q;
   // The memory re-reads the held o_PC while frozen, which is the address
   // after the in-flight one. The in-flight word is therefore captured on the
   // first frozen cycle and replayed when the stage advances again.
   logic [NBITS-1:0] held_instr_q;
   logic             held_valid_q;

   logic             redirect;
   logic [NBITS-1:0] redirect_target;
   logic [NBITS-1:0] fetched_instr;
   logic             advance;
   logic             halt_load;
   logic             ifid_bubble;
   logic [NBITS-1:0] ifid_instr_d;
   logic [NBITS-1:0] ifid_pc4_d;

   assign redirect        = i_jump | i_branch_taken;
   assign redirect_target = i_jump ? i_jump_target : i_branch_target;
   assign fetched_instr   = held_valid_q ? held_instr_q : i_instruction;

   assign advance   = i_enable && (state_q == StRun) && !redirect && !i_stall;
   assign halt_load = advance && inflight_valid_q && (fetched_instr == HALT_INSTR);

   assign ifid_bubble  = i_enable && ((state_q == StHalted) || redirect);
   // An invalid in-flight slot still loads as a clean bubble.
   assign ifid_instr_d = inflight_valid_q ? fetched_instr : NBITS'(NOP_INSTR);
   assign ifid_pc4_d   = inflight_valid_q ? (inflight_pc_q + PC_STEP) : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q          <= StRun;
         pc_q             <= PC_RESET;
         inflight_pc_q    <= PC_RESET;
         inflight_valid_q <= 1'b0;
         held_instr_q     <= '0;
         held_valid_q     <= 1'b0;
      end else if (!i_enable) begin
         if ((state_q == StRun) && !held_valid_q) begin
            held_instr_q <= i_instruction;
            held_valid_q <= 1'b1;
         end
      end else begin
         unique case (state_q)
            StRun: begin
               if (redirect) begin
                  pc_q             <= redirect_target;
                  inflight_valid_q <= 1'b0;
                  held_valid_q     <= 1'b0;
               end else if (i_stall) begin
                  if (!held_valid_q) begin
                     held_instr_q <= i_instruction;
                     held_valid_q <= 1'b1;
                  end
               end else begin
                  pc_q             <= pc_q + PC_STEP;
                  inflight_pc_q    <= pc_q;
                  inflight_valid_q <= 1'b1;
                  held_valid_q     <= 1'b0;
                  if (halt_load) begin
                     state_q <= StHalted;
                  end
               end
            end
            StHalted: begin
               // Only reset leaves this state; PC is frozen.
            end
            default: begin
               state_q <= StRun;
            end
         endcase
      end
   end

   registro_ifid #(
      .NBITS (NBITS)
   ) u_registro_ifid (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (advance),
      .i_bubble (ifid_bubble),
      .i_instr  (ifid_instr_d),
      .i_pc4    (ifid_pc4_d),
      .i_valid  (inflight_valid_q),
      .o_instr  (o_ifid_instr),
      .o_pc4    (o_ifid_pc4),
      .o_valid  (o_ifid_valid)
   );

   assign o_PC     = pc_q;
   assign o_halted = (state_q == StHalted);

endmodule

// File: tb/tb_etapa_fetch.sv
// Directed bench for etapa_fetch with PC_RESET = 4 and a registered-read
// instruction memory model whose word at address a is 0xC0DE_0000 | a.
module tb_etapa_fetch;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   typedef struct packed {
      logic        en;
      logic        st;
      logic        br;
      logic [31:0] bt;
      logic        jp;
      logic [31:0] jt;
   } stim_t;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] mem_q;
   logic [31:0] pc;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        halted;
   logic        halt_on;
   logic [97:0] obs;

   int n_cmp;
   int n_bad;

   etapa_fetch #(
      .PC_RESET (32'd4)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_enable        (enable),
      .i_stall         (stall),
      .i_branch_taken  (branch_taken),
      .i_branch_target (branch_target),
      .i_jump          (jump),
      .i_jump_target   (jump_target),
      .i_instruction   (mem_q),
      .o_PC            (pc),
      .o_ifid_instr    (ifid_instr),
      .o_ifid_pc4      (ifid_pc4),
      .o_ifid_valid    (ifid_valid),
      .o_halted        (halted)
   );

   assign obs = {pc, ifid_instr, ifid_pc4, ifid_valid, halted};

   function automatic logic [31:0] w(input logic [31:0] a);
      return (halt_on && a == 32'd16) ? HALT : (32'hC0DE_0000 | a);
   endfunction

   // Registered-read instruction memory.
   always @(posedge clk) mem_q <= w(pc);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic stim_t sv(input logic en, st, br, input logic [31:0] bt,
                                input logic jp, input logic [31:0] jt);
      stim_t s;
      s = '{en: en, st: st, br: br, bt: bt, jp: jp, jt: jt};
      return s;
   endfunction

   function automatic logic [97:0] ev(input logic [31:0] p, i, p4, input logic v, h);
      return {p, i, p4, v, h};
   endfunction

   task automatic drive(input stim_t s);
      enable        = s.en;
      stall         = s.st;
      branch_taken  = s.br;
      branch_target = s.bt;
      jump          = s.jp;
      jump_target   = s.jt;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [97:0] e;
      enable = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      branch_target = '0; jump_target = '0; halt_on = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      e = ev(32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== e) begin
         n_bad++;
         $display("FAIL reset: got %h expected %h", obs, e);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_free_run();
      stim_t       s [3];
      logic [97:0] e [3];
      for (int i = 0; i < 3; i++) s[i] = sv(1, 0, 0, 0, 0, 0);
      e[0] = ev(32'd8,  32'd0,  32'd0,  1'b0, 1'b0);
      e[1] = ev(32'd12, w(4),   32'd8,  1'b1, 1'b0);
      e[2] = ev(32'd16, w(8),   32'd12, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(s[i]);
         n_cmp++;
         if (obs !== e[i]) begin
            n_bad++;
            $display("FAIL free_run[%0d]: got %h expected %h", i, obs, e[i]);
         end
      end
   endtask

   task automatic test_stall();
      stim_t       s [4];
      logic [97:0] e [4];
      for (int i = 0; i < 3; i++) begin
         s[i] = sv(1, 1, 0, 0, 0, 0);
         e[i] = ev(32'd16, w(8), 32'd12, 1'b1, 1'b0);
      end
      s[3] = sv(1, 0, 0, 0, 0, 0);
      e[3] = ev(32'd20, w(12), 32'd16, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(s[i]);
         n_cmp++;
         if (obs !== e[i]) begin
            n_bad++;
            $display("FAIL stall[%0d]: got %h expected %h", i, obs, e[i]);
         end
      end
   endtask

   task automatic test_branch();
      stim_t       s [6];
      logic [97:0] e [6];
      s[0] = sv(1, 0, 1, 32'd52, 0, 0);
      s[1] = sv(1, 0, 0, 0, 0, 0);
      s[2] = sv(1, 0, 0, 0, 0, 0);
      s[3] = sv(1, 1, 1, 32'd52, 0, 0);
      s[4] = sv(1, 0, 0, 0, 0, 0);
      s[5] = sv(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         e[3*k]   = ev(32'd52, 32'd0, 32'd0,  1'b0, 1'b0);
         e[3*k+1] = ev(32'd56, 32'd0, 32'd0,  1'b0, 1'b0);
         e[3*k+2] = ev(32'd60, w(52), 32'd56, 1'b1, 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
         drive(s[i]);
         n_cmp++;
         if (obs !== e[i]) begin
            n_bad++;
            $display("FAIL branch[%0d]: got %h expected %h", i, obs, e[i]);
         end
      end
   endtask

   task automatic test_jump_priority();
      stim_t       s [3];
      logic [97:0] e [3];
      s[0] = sv(1, 0, 1, 32'd52, 1, 32'd40);
      s[1] = sv(1, 0, 0, 0, 0, 0);
      s[2] = sv(1, 0, 0, 0, 0, 0);
      e[0] = ev(32'd40, 32'd0, 32'd0,  1'b0, 1'b0);
      e[1] = ev(32'd44, 32'd0, 32'd0,  1'b0, 1'b0);
      e[2] = ev(32'd48, w(40), 32'd44, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(s[i]);
         n_cmp++;
         if (obs !== e[i]) begin
            n_bad++;
            $display("FAIL jump_priority[%0d]: got %h expected %h", i, obs, e[i]);
         end
      end
   endtask

   task automatic test_halt();
      stim_t       s [11];
      logic [97:0] e [11];
      halt_on = 1'b1;
      // Halt word squashed by a redirect on the cycle it would load.
      s[0]  = sv(1, 0, 0, 0, 1, 32'd16);
      s[1]  = sv(1, 0, 0, 0, 0, 0);
      s[2]  = sv(1, 0, 1, 32'd52, 0, 0);
      s[3]  = sv(1, 0, 0, 0, 0, 0);
      s[4]  = sv(1, 0, 0, 0, 0, 0);
      e[0]  = ev(32'd16, 32'd0, 32'd0,  1'b0, 1'b0);
      e[1]  = ev(32'd20, 32'd0, 32'd0,  1'b0, 1'b0);
      e[2]  = ev(32'd52, 32'd0, 32'd0,  1'b0, 1'b0);
      e[3]  = ev(32'd56, 32'd0, 32'd0,  1'b0, 1'b0);
      e[4]  = ev(32'd60, w(52), 32'd56, 1'b1, 1'b0);
      // Real halt.
      s[5]  = sv(1, 0, 0, 0, 1, 32'd16);
      s[6]  = sv(1, 0, 0, 0, 0, 0);
      s[7]  = sv(1, 0, 0, 0, 0, 0);
      s[8]  = sv(1, 0, 0, 0, 0, 0);
      s[9]  = sv(1, 0, 1, 32'd52, 0, 0);
      s[10] = sv(1, 1, 0, 0, 1, 32'd40);
      e[5]  = ev(32'd16, 32'd0, 32'd0,  1'b0, 1'b0);
      e[6]  = ev(32'd20, 32'd0, 32'd0,  1'b0, 1'b0);
      e[7]  = ev(32'd24, HALT,  32'd20, 1'b1, 1'b1);
      e[8]  = ev(32'd24, 32'd0, 32'd0,  1'b0, 1'b1);
      e[9]  = ev(32'd24, 32'd0, 32'd0,  1'b0, 1'b1);
      e[10] = ev(32'd24, 32'd0, 32'd0,  1'b0, 1'b1);
      for (int i = 0; i < 11; i++) begin
         drive(s[i]);
         n_cmp++;
         if (obs !== e[i]) begin
            n_bad++;
            $display("FAIL halt[%0d]: got %h expected %h", i, obs, e[i]);
         end
      end
   endtask

   task automatic test_reset_enable();
      stim_t       s [8];
      logic [97:0] e [8];
      logic [97:0] er;
      // Asynchronous reset mid-cycle, away from any clock edge.
      rst_n = 1'b0;
      #1;
      er = ev(32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== er) begin
         n_bad++;
         $display("FAIL async_reset: got %h expected %h", obs, er);
      end
      halt_on = 1'b0;
      enable  = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      s[0] = sv(0, 0, 0, 0, 0, 0);
      s[1] = sv(0, 0, 0, 0, 0, 0);
      s[2] = sv(1, 0, 0, 0, 0, 0);
      s[3] = sv(0, 0, 0, 0, 0, 0);
      s[4] = sv(0, 0, 1, 32'd52, 0, 0);
      s[5] = sv(1, 0, 0, 0, 0, 0);
      s[6] = sv(0, 1, 0, 0, 1, 32'd40);
      s[7] = sv(1, 0, 0, 0, 0, 0);
      e[0] = ev(32'd4,  32'd0, 32'd0,  1'b0, 1'b0);
      e[1] = ev(32'd4,  32'd0, 32'd0,  1'b0, 1'b0);
      e[2] = ev(32'd8,  32'd0, 32'd0,  1'b0, 1'b0);
      e[3] = ev(32'd8,  32'd0, 32'd0,  1'b0, 1'b0);
      e[4] = ev(32'd8,  32'd0, 32'd0,  1'b0, 1'b0);
      e[5] = ev(32'd12, w(4),  32'd8,  1'b1, 1'b0);
      e[6] = ev(32'd12, w(4),  32'd8,  1'b1, 1'b0);
      e[7] = ev(32'd16, w(8),  32'd12, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         drive(s[i]);
         n_cmp++;
         if (obs !== e[i]) begin
            n_bad++;
            $display("FAIL reset_enable[%0d]: got %h expected %h", i, obs, e[i]);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_free_run();
      test_stall();
      test_branch();
      test_jump_priority();
      test_halt();
      test_reset_enable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
